// File: rtl/arm_mac_seq.sv
// Iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL sequencer: consumes BPC bits of Rs per cycle,
// then writes RdLo (and RdHi for long ops) through the single register-file write port.
module arm_mac_seq #(
    parameter int BPC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  op,
    input  logic        set_flags,
    input  logic [3:0]  rd_lo_idx,
    input  logic [3:0]  rd_hi_idx,
    input  logic [31:0] op_m,
    input  logic [31:0] op_s,
    input  logic [31:0] acc_lo,
    input  logic [31:0] acc_hi,
    output logic        busy,
    output logic        done,
    output logic        rd_we,
    output logic [3:0]  write_rd,
    output logic [31:0] rd_in,
    output logic        flags_we,
    output logic        flag_n,
    output logic        flag_z
);
    localparam int N_ITER = 32 / BPC;
    localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   iter;
    logic            is_long;
    logic            is_signed;
    logic            upd_flags;
    logic [3:0]      lo_idx;
    logic [3:0]      hi_idx;
    logic [63:0]     acc;
    logic [63:0]     mcand;
    logic [31:0]     mplier;
    logic [BPC-1:0]  digit;
    logic [63:0]     pp;
    logic            last_iter;
    logic            launch;
    logic            wr_lo;
    logic            wr_hi;
    logic            final_wr;

    assign launch    = (state == IDLE) && start && !flush;
    assign last_iter = (iter == CW'(N_ITER - 1));
    assign digit     = mplier[BPC-1:0];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pp = mcand * 64'(digit);
        // In a signed multiply the top Rs digit carries negative weight.
        if (is_signed && last_iter && digit[BPC-1]) begin
            pp = pp - (mcand << BPC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            iter  <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        iter  <= '0;
                    end
                end
                CALC: begin
                    iter <= iter + CW'(1);
                    if (last_iter) state <= WR_LO;
                end
                WR_LO:   state <= is_long ? WR_HI : IDLE;
                WR_HI:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; every output that exposes them is gated by state.
    always_ff @(posedge clk) begin
        if (launch) begin
            is_long   <= op[1];
            is_signed <= op[2] & op[1];
            upd_flags <= set_flags;
            lo_idx    <= rd_lo_idx;
            hi_idx    <= rd_hi_idx;
            mcand     <= (op[2] & op[1]) ? {{32{op_m[31]}}, op_m} : {32'b0, op_m};
            mplier    <= op_s;
            acc       <= op[0] ? {op[1] ? acc_hi : 32'b0, acc_lo} : 64'b0;
        end else if (state == CALC) begin
            acc    <= acc + pp;
            mcand  <= mcand << BPC;
            mplier <= mplier >> BPC;
        end
    end

    assign wr_lo    = (state == WR_LO);
    assign wr_hi    = (state == WR_HI);
    assign final_wr = wr_hi | (wr_lo & ~is_long);

    always_comb begin
        busy     = (state != IDLE);
        rd_we    = wr_lo | wr_hi;
        done     = final_wr;
        flags_we = final_wr & upd_flags;
        flag_n   = 1'b0;
        flag_z   = 1'b0;
        write_rd = 4'h0;
        rd_in    = 32'h0;
        if (wr_lo) begin
            write_rd = lo_idx;
            rd_in    = acc[31:0];
        end else if (wr_hi) begin
            write_rd = hi_idx;
            rd_in    = acc[63:32];
        end
        if (final_wr) begin
            flag_n = is_long ? acc[63] : acc[31];
            flag_z = is_long ? (acc == 64'b0) : (acc[31:0] == 32'b0);
        end
    end
endmodule

// File: tb/tb_arm_mac_seq.sv
// Scoreboard bench for arm_mac_seq: expected register writes are queued at launch
// and compared, cycle-exact, whenever the DUT asserts rd_we.
module tb_arm_mac_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic        set_flags;
    logic [3:0]  rd_lo_idx;
    logic [3:0]  rd_hi_idx;
    logic [31:0] op_m;
    logic [31:0] op_s;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic        busy;
    logic        done;
    logic        rd_we;
    logic [3:0]  write_rd;
    logic [31:0] rd_in;
    logic        flags_we;
    logic        flag_n;
    logic        flag_z;

    arm_mac_seq #(.BPC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .set_flags(set_flags), .rd_lo_idx(rd_lo_idx), .rd_hi_idx(rd_hi_idx),
        .op_m(op_m), .op_s(op_s), .acc_lo(acc_lo), .acc_hi(acc_hi),
        .busy(busy), .done(done), .rd_we(rd_we), .write_rd(write_rd), .rd_in(rd_in),
        .flags_we(flags_we), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [31:0] data;
        logic        done;
        logic        fwe;
        logic        n;
        logic        z;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] m, input logic [31:0] s,
                                          input logic [31:0] al, input logic [31:0] ah);
        logic [63:0] a;
        logic [63:0] p;
        a = o[0] ? {o[1] ? ah : 32'h0, al} : 64'h0;
        if (o[2] && o[1]) p = 64'(longint'(signed'(m)) * longint'(signed'(s)));
        else              p = {32'h0, m} * {32'h0, s};
        return a + p;
    endfunction

    // Register-write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rd_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write cyc=%0d write_rd=%0d rd_in=%h done=%b flags_we=%b",
                         cyc, write_rd, rd_in, done, flags_we);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc !== mon_e.cyc || write_rd !== mon_e.idx || rd_in !== mon_e.data ||
                    done !== mon_e.done || flags_we !== mon_e.fwe ||
                    (mon_e.fwe && (flag_n !== mon_e.n || flag_z !== mon_e.z))) begin
                    n_fail++;
                    $display("FAIL write got cyc=%0d rd=%0d data=%h done=%b fwe=%b n=%b z=%b exp cyc=%0d rd=%0d data=%h done=%b fwe=%b n=%b z=%b",
                             cyc, write_rd, rd_in, done, flags_we, flag_n, flag_z,
                             mon_e.cyc, mon_e.idx, mon_e.data, mon_e.done, mon_e.fwe, mon_e.n, mon_e.z);
                end
            end
        end else if (rst === 1'b0) begin
            n_checks++;
            if (done !== 1'b0 || flags_we !== 1'b0 || rd_we !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_strobes cyc=%0d rd_we=%b done=%b flags_we=%b exp all 0",
                         cyc, rd_we, done, flags_we);
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            if (busy === 1'b0) begin
                t = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Drives one start pulse from the current negedge and queues nw writes (-1: all of them).
    task automatic launch(input logic [2:0] o, input logic sf, input logic [3:0] lo, input logic [3:0] hi,
                          input logic [31:0] m, input logic [31:0] s, input logic [31:0] al,
                          input logic [31:0] ah, input int nw, output int t0);
        logic [63:0] r;
        wr_t e;
        int n;
        r  = model(o, m, s, al, ah);
        n  = (nw < 0) ? (o[1] ? 2 : 1) : nw;
        t0 = cyc;
        op = o; set_flags = sf; rd_lo_idx = lo; rd_hi_idx = hi;
        op_m = m; op_s = s; acc_lo = al; acc_hi = ah;
        start = 1'b1;
        if (n >= 1) begin
            e.cyc = t0 + 9; e.idx = lo; e.data = r[31:0];
            e.done = !o[1]; e.fwe = !o[1] && sf; e.n = r[31]; e.z = (r[31:0] == 32'h0);
            exp_q.push_back(e);
        end
        if (n >= 2) begin
            e.cyc = t0 + 10; e.idx = hi; e.data = r[63:32];
            e.done = 1'b1; e.fwe = sf; e.n = r[63]; e.z = (r == 64'h0);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        // Operands must have been latched; scramble the inputs.
        op = 3'($urandom); set_flags = 1'($urandom);
        rd_lo_idx = 4'($urandom); rd_hi_idx = 4'($urandom);
        op_m = $urandom; op_s = $urandom; acc_lo = $urandom; acc_hi = $urandom;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s pending_writes=%0d exp 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b0; set_flags = 1'b0;
        rd_lo_idx = 4'h0; rd_hi_idx = 4'h0; op_m = '0; op_s = '0; acc_lo = '0; acc_hi = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, rd_we, flags_we, flag_n, flag_z} !== 6'b0 || write_rd !== 4'h0 || rd_in !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b we=%b fwe=%b n=%b z=%b rd=%h data=%h exp all 0",
                     busy, done, rd_we, flags_we, flag_n, flag_z, write_rd, rd_in);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rd_in !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle got busy=%b rd_in=%h exp 0 0", busy, rd_in);
        end
    endtask

    task automatic test_mul();
        int t0, t;
        launch(3'b000, 1'b0, 4'd3, 4'd0, 32'd7, 32'd6, 32'd0, 32'd0, -1, t0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_busy_high got %b exp 1", busy);
        end
        wait_idle(30, t);
        n_checks++;
        if (t != t0 + 10) begin
            n_fail++;
            $display("FAIL mul_busy_low got cyc=%0d exp %0d (-1 = timeout)", t, t0 + 10);
        end
        check_drained("mul_writes");
    endtask

    task automatic test_long_ops();
        int t0, t;
        launch(3'b010, 1'b0, 4'd1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, -1, t0);
        wait_idle(30, t);
        n_checks++;
        if (t != t0 + 11) begin
            n_fail++;
            $display("FAIL umull_busy_low got cyc=%0d exp %0d", t, t0 + 11);
        end
        check_drained("umull_writes");
        launch(3'b111, 1'b1, 4'd4, 4'd5, 32'hFFFFFFFE, 32'd3, 32'd5, 32'd0, -1, t0);
        wait_idle(30, t);
        check_drained("smlal_writes");
        launch(3'b001, 1'b1, 4'd6, 4'd0, 32'h80000000, 32'd2, 32'd0, 32'd0, -1, t0);
        wait_idle(30, t);
        check_drained("mla_zero_flags");
    endtask

    task automatic test_back_to_back();
        int t0, t;
        for (int i = 0; i < 14; i++) begin
            launch(3'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                   (i == 0) ? 32'h80000000 : $urandom, (i == 1) ? 32'h80000000 : $urandom,
                   $urandom, $urandom, -1, t0);
            wait_idle(30, t);
            n_checks++;
            if (t < 0) begin
                n_fail++;
                $display("FAIL b2b_timeout op_index=%0d got -1 exp idle", i);
            end
        end
        check_drained("b2b_writes");
    endtask

    task automatic test_flush();
        int t0, t, bad;
        launch(3'b000, 1'b1, 4'd7, 4'd0, 32'd9, 32'd9, 32'd0, 32'd0, 0, t0);
        goto(t0 + 2);
        start = 1'b1;
        goto(t0 + 3);
        start = 1'b0;
        goto(t0 + 4);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre_busy got %b exp 1", busy);
        end
        flush = 1'b1;
        goto(t0 + 5);
        flush = 1'b0;
        bad = 0;
        repeat (16) begin
            if (busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL flush_idle busy_cycles got %0d exp 0", bad);
        end
        check_drained("flush_writes");

        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_beats_start got busy=%b exp 0", busy);
        end

        launch(3'b011, 1'b1, 4'd8, 4'd9, $urandom, $urandom, $urandom, $urandom, 1, t0);
        goto(t0 + 9);
        flush = 1'b1;
        goto(t0 + 10);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wr_lo got busy=%b exp 0", busy);
        end
        repeat (4) @(negedge clk);
        check_drained("flush_wr_lo_writes");
    endtask

    task automatic test_reset_mid_op();
        int t0;
        launch(3'b010, 1'b1, 4'd10, 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1, t0);
        goto(t0 + 8);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rd_we !== 1'b0 || cyc != t0 + 10) begin
            n_fail++;
            $display("FAIL rst_mid_op got busy=%b rd_we=%b cyc=%0d exp 0 0 %0d", busy, rd_we, cyc, t0 + 10);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_drained("rst_mid_op_writes");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_long_ops();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
